// File: rtl/seg_display_pkg.sv
// Shared definitions for the 7-segment display blocks: digit modes, hex glyph table
// and the per-digit register-file entry.
package seg_display_pkg;

  typedef enum logic [1:0] {
    MODE_HEX   = 2'b00,
    MODE_BCD   = 2'b01,
    MODE_RAW   = 2'b10,
    MODE_BLANK = 2'b11
  } mode_e;

  // Segment order is {g,f,e,d,c,b,a}; entry [15] is listed first.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef struct packed {
    logic [6:0] value;   // [3:0] digit value, or raw segments a..g in raw mode
    mode_e      mode;
    logic       dp;
    logic       blink;
  } digit_entry_t;

endpackage

// File: rtl/seg_glyph_rom.sv
// Combinational glyph lookup: digit value + display mode (+ raw pattern) -> segments a..g.
module seg_glyph_rom
  import seg_display_pkg::*;
(
  input  logic [3:0] value,
  input  mode_e      mode,
  input  logic [6:0] raw,
  output logic [6:0] glyph
);

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latch).
    glyph = '0;
    case (mode)
      MODE_HEX: glyph = HEX_GLYPH[value];
      MODE_BCD: glyph = (value <= 4'd9) ? HEX_GLYPH[value] : 7'h00;
      MODE_RAW: glyph = raw;
      default:  glyph = '0;
    endcase
  end

endmodule

// File: rtl/multiplexed_segment_scanner.sv
// Time-multiplexed N-digit 7-segment driver: host register file, per-frame shadow copy,
// digit scan with ghost-blanking gap, ripple blanking, blink, lamp test and blank-all.
module multiplexed_segment_scanner
  import seg_display_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int SLOT_CYCLES  = 1024,
  parameter int GAP_CYCLES   = 16,
  parameter int BLINK_FRAMES = 32,
  parameter bit DIG_AL       = 1'b1,
  localparam int AW          = $clog2(N_DIGITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [7:0]          wr_data,
  input  logic [1:0]          wr_mode,
  input  logic                wr_dp,
  input  logic                wr_blink,
  input  logic                lt,
  input  logic                bi,
  input  logic                rbi,
  input  logic                al,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [N_DIGITS-1:0] dig_sel,
  output logic                frame_tick
);

  localparam int SW = $clog2(SLOT_CYCLES);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0] GAP_END    = SW'(GAP_CYCLES);
  localparam logic [AW-1:0] DIGIT_LAST = AW'(N_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES);
  localparam logic [AW:0]   ADDR_LIM   = (AW + 1)'(N_DIGITS);

  digit_entry_t regs   [N_DIGITS];
  digit_entry_t shadow [N_DIGITS];
  digit_entry_t view   [N_DIGITS];
  digit_entry_t cur;

  logic [SW-1:0]       slot_cnt;
  logic [AW-1:0]       digit_idx;
  logic [FW-1:0]       frame_cnt;
  logic                blink_on, blink_next, boundary, in_gap, carry;
  logic [N_DIGITS-1:0] rb_blank, sel_n;
  logic [6:0]          glyph, seg_n, seg_q;
  logic                dp_n, dp_q;
  logic                unused_bits;

  assign unused_bits = wr_data[7];
  assign boundary    = (digit_idx == '0) && (slot_cnt == '0);
  assign blink_next  = blink_on ^ (boundary && (frame_cnt == FRAME_LAST));
  assign in_gap      = slot_cnt < GAP_END;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the register file is small and must read back as cleared, so it sits in the reset branch like any other flop.
      for (int i = 0; i < N_DIGITS; i++) regs[i] <= '0;
    end else if (wr_en && ({1'b0, wr_addr} < ADDR_LIM)) begin
      // NOTE: state updates use <= so every flop samples pre-edge values (shadow below captures the pre-write entry).
      regs[wr_addr] <= '{value: wr_data[6:0], mode: mode_e'(wr_mode), dp: wr_dp, blink: wr_blink};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_DIGITS; i++) shadow[i] <= '0;
    end else if (boundary) begin
      for (int i = 0; i < N_DIGITS; i++) shadow[i] <= regs[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      if (slot_cnt == SLOT_LAST) begin
        slot_cnt  <= '0;
        digit_idx <= (digit_idx == DIGIT_LAST) ? '0 : digit_idx + AW'(1);
      end else begin
        slot_cnt <= slot_cnt + SW'(1);
      end
      // The boundary itself counts as a frame, so after a toggle the count restarts at 1.
      if (boundary) frame_cnt <= (frame_cnt == FRAME_LAST) ? FW'(1) : frame_cnt + FW'(1);
      blink_on <= blink_next;
    end
  end

  // On the boundary cycle the pins must already reflect the frame being loaded.
  always_comb begin
    for (int i = 0; i < N_DIGITS; i++) view[i] = boundary ? regs[i] : shadow[i];
  end

  always_comb begin
    rb_blank = '0;
    carry    = rbi;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      carry = carry && (view[i].mode inside {MODE_HEX, MODE_BCD}) &&
              (view[i].value[3:0] == 4'd0) && !view[i].dp;
      rb_blank[i] = carry;
    end
  end

  assign cur = view[digit_idx];

  seg_glyph_rom u_glyph (
    .value (cur.value[3:0]),
    .mode  (cur.mode),
    .raw   (cur.value),
    .glyph (glyph)
  );

  always_comb begin
    seg_n = '0;
    dp_n  = 1'b0;
    sel_n = '0;
    if (!in_gap) begin
      sel_n[digit_idx] = 1'b1;
      if (bi) begin
        seg_n = '0;
      end else if (lt) begin
        seg_n = 7'h7F;
        dp_n  = 1'b1;
      end else if (!rb_blank[digit_idx] && !(cur.blink && !blink_next)) begin
        seg_n = glyph;
        dp_n  = cur.dp;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q      <= '0;
      dp_q       <= 1'b0;
      dig_sel    <= {N_DIGITS{DIG_AL}};
      frame_tick <= 1'b0;
    end else begin
      seg_q      <= seg_n;
      dp_q       <= dp_n;
      dig_sel    <= sel_n ^ {N_DIGITS{DIG_AL}};
      frame_tick <= boundary;
    end
  end

  // al is a board strap; applying it after the flops keeps the reset state "off" for either polarity.
  assign seg = seg_q ^ {7{al}};
  assign dp  = dp_q ^ al;

endmodule

// File: tb/tb_multiplexed_segment_scanner.sv
// Directed bench for multiplexed_segment_scanner (N=4, 8-cycle slots, 2-cycle gap, 2-frame blink).
module tb_multiplexed_segment_scanner;
  import seg_display_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, wr_dp, wr_blink, lt, bi, rbi, al;
  logic [1:0] wr_addr, wr_mode;
  logic [7:0] wr_data;
  logic [6:0] seg;
  logic       dp, frame_tick;
  logic [3:0] dig_sel;

  int checks   = 0;
  int failures = 0;

  multiplexed_segment_scanner #(
    .N_DIGITS(4), .SLOT_CYCLES(8), .GAP_CYCLES(2), .BLINK_FRAMES(2), .DIG_AL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mode(wr_mode), .wr_dp(wr_dp), .wr_blink(wr_blink), .lt(lt), .bi(bi),
    .rbi(rbi), .al(al), .seg(seg), .dp(dp), .dig_sel(dig_sel), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench on the negedge where frame_tick is high (scan offset 0 = digit 0, slot 0).
  task automatic wait_tick();
    logic found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = frame_tick;
    end
    check("frame_tick_seen", {31'd0, found}, 32'd1);
  endtask

  task automatic wr(input logic [1:0] addr, input logic [1:0] mode, input logic [7:0] data,
                    input logic dpv, input logic blk);
    wr_en = 1'b1; wr_addr = addr; wr_mode = mode; wr_data = data; wr_dp = dpv; wr_blink = blk;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_mode = '0; wr_data = '0;
    wr_dp = 1'b0; wr_blink = 1'b0; lt = 1'b0; bi = 1'b0; rbi = 1'b0; al = 1'b0;
    adv(3);
    check("reset_seg", {25'd0, seg}, 32'h00);
    check("reset_dp", {31'd0, dp}, 32'd0);
    check("reset_dig_sel", {28'd0, dig_sel}, 32'hF);
    check("reset_frame_tick", {31'd0, frame_tick}, 32'd0);
    rst = 1'b0;

    // 1: hex 1,2,3,4 on digits 3..0
    wr(2'd3, 2'b00, 8'h01, 1'b0, 1'b0);
    wr(2'd2, 2'b00, 8'h02, 1'b0, 1'b0);
    wr(2'd1, 2'b00, 8'h03, 1'b0, 1'b0);
    wr(2'd0, 2'b00, 8'h04, 1'b0, 1'b0);
    wait_tick();
    check("t1_gap0_sel", {28'd0, dig_sel}, 32'hF);
    check("t1_gap0_seg", {25'd0, seg}, 32'h00);
    adv(1);
    check("t1_gap1_sel", {28'd0, dig_sel}, 32'hF);
    check("t1_tick_pulse", {31'd0, frame_tick}, 32'd0);
    adv(1);
    check("t1_d0_sel", {28'd0, dig_sel}, 32'hE);
    check("t1_d0_seg", {25'd0, seg}, 32'h66);
    adv(8);
    check("t1_d1_sel", {28'd0, dig_sel}, 32'hD);
    check("t1_d1_seg", {25'd0, seg}, 32'h4F);
    adv(8);
    check("t1_d2_seg", {25'd0, seg}, 32'h5B);
    adv(8);
    check("t1_d3_sel", {28'd0, dig_sel}, 32'h7);
    check("t1_d3_seg", {25'd0, seg}, 32'h06);

    // 2: leading-zero suppression, BCD 0,0,5,0
    rbi = 1'b1;
    wr(2'd3, 2'b01, 8'h00, 1'b0, 1'b0);
    wr(2'd2, 2'b01, 8'h00, 1'b0, 1'b0);
    wr(2'd1, 2'b01, 8'h05, 1'b0, 1'b0);
    wr(2'd0, 2'b01, 8'h00, 1'b0, 1'b0);
    wait_tick();
    adv(2);
    check("t2_d0_seg", {25'd0, seg}, 32'h3F);
    adv(8);
    check("t2_d1_seg", {25'd0, seg}, 32'h6D);
    adv(8);
    check("t2_d2_seg_blank", {25'd0, seg}, 32'h00);
    check("t2_d2_sel", {28'd0, dig_sel}, 32'hB);
    adv(8);
    check("t2_d3_seg_blank", {25'd0, seg}, 32'h00);
    rbi = 1'b0;
    wait_tick();
    adv(18);
    check("t2_norbi_d2", {25'd0, seg}, 32'h3F);
    adv(8);
    check("t2_norbi_d3", {25'd0, seg}, 32'h3F);
    // dp on digit 2 stops the chain; BCD 12 is blank
    rbi = 1'b1;
    wr(2'd2, 2'b01, 8'h00, 1'b1, 1'b0);
    wr(2'd0, 2'b01, 8'h0C, 1'b0, 1'b0);
    wait_tick();
    adv(2);
    check("t2_bcd12_blank", {25'd0, seg}, 32'h00);
    adv(16);
    check("t2_dp_d2_seg", {25'd0, seg}, 32'h3F);
    check("t2_dp_d2_dp", {31'd0, dp}, 32'd1);
    adv(8);
    check("t2_dp_d3_blank", {25'd0, seg}, 32'h00);
    rbi = 1'b0;

    // 3: tear-free update of digit 1
    wait_tick();
    adv(5);
    wr(2'd1, 2'b00, 8'h08, 1'b0, 1'b0);
    adv(4);
    check("t3_old_glyph", {25'd0, seg}, 32'h6D);
    wait_tick();
    adv(10);
    check("t3_new_glyph", {25'd0, seg}, 32'h7F);
    adv(21);
    wr(2'd1, 2'b00, 8'h01, 1'b0, 1'b0);
    check("t3_coincident_tick", {31'd0, frame_tick}, 32'd1);
    adv(10);
    check("t3_coincident_held", {25'd0, seg}, 32'h7F);
    wait_tick();
    adv(10);
    check("t3_coincident_shown", {25'd0, seg}, 32'h06);

    // 6: async reset mid-slot
    adv(3);
    check("t6_pre_sel", {28'd0, dig_sel}, 32'hD);
    #2 rst = 1'b1;
    #1;
    check("t6_async_seg", {25'd0, seg}, 32'h00);
    check("t6_async_sel", {28'd0, dig_sel}, 32'hF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t6_held_sel", {28'd0, dig_sel}, 32'hF);
    rst = 1'b0;
    adv(1);
    check("t6_tick_after_release", {31'd0, frame_tick}, 32'd1);
    check("t6_gap_sel", {28'd0, dig_sel}, 32'hF);
    adv(1);
    check("t6_tick_single", {31'd0, frame_tick}, 32'd0);
    adv(1);
    check("t6_restart_d0_sel", {28'd0, dig_sel}, 32'hE);
    check("t6_cleared_d0_seg", {25'd0, seg}, 32'h3F);

    // 4: blink on digit 2 (frame 0 is now running)
    wr(2'd2, 2'b00, 8'h0A, 1'b1, 1'b1);
    wr(2'd1, 2'b00, 8'h0C, 1'b0, 1'b0);
    wait_tick();
    adv(18);
    check("t4_f1_on_seg", {25'd0, seg}, 32'h77);
    check("t4_f1_on_dp", {31'd0, dp}, 32'd1);
    wait_tick();
    adv(10);
    check("t4_f2_d1_unaffected", {25'd0, seg}, 32'h39);
    adv(8);
    check("t4_f2_off_seg", {25'd0, seg}, 32'h00);
    check("t4_f2_off_dp", {31'd0, dp}, 32'd0);
    check("t4_f2_off_sel", {28'd0, dig_sel}, 32'hB);
    wait_tick();
    adv(18);
    check("t4_f3_off_seg", {25'd0, seg}, 32'h00);
    wait_tick();
    adv(18);
    check("t4_f4_on_seg", {25'd0, seg}, 32'h77);

    // 5: lamp test, blank-all, active-low segments
    lt = 1'b1;
    adv(1);
    check("t5_lt_seg", {25'd0, seg}, 32'h7F);
    check("t5_lt_dp", {31'd0, dp}, 32'd1);
    check("t5_lt_sel", {28'd0, dig_sel}, 32'hB);
    bi = 1'b1;
    adv(1);
    check("t5_bi_seg", {25'd0, seg}, 32'h00);
    check("t5_bi_dp", {31'd0, dp}, 32'd0);
    bi = 1'b0; al = 1'b1;
    adv(1);
    check("t5_al_lt_seg", {25'd0, seg}, 32'h00);
    lt = 1'b0;
    adv(1);
    check("t5_al_glyph_seg", {25'd0, seg}, 32'h08);
    check("t5_al_glyph_dp", {31'd0, dp}, 32'd0);
    al = 1'b0;

    // 7: raw digit breaks the ripple chain
    rbi = 1'b1;
    wr(2'd3, 2'b01, 8'h00, 1'b0, 1'b0);
    wr(2'd2, 2'b10, 8'hC9, 1'b0, 1'b0);
    wr(2'd1, 2'b01, 8'h00, 1'b0, 1'b0);
    wr(2'd0, 2'b01, 8'h0C, 1'b0, 1'b0);
    wait_tick();
    adv(10);
    check("t7_d1_after_raw", {25'd0, seg}, 32'h3F);
    adv(8);
    check("t7_d2_raw", {25'd0, seg}, 32'h49);
    adv(8);
    check("t7_d3_blank", {25'd0, seg}, 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
